// File: rtl/rdmx_xmit_framer.sv
// RDMX transmit framer: buffers one packet, then emits a header beat followed by the buffered data.
// Optional statistics counters are enabled by defining RDMX_FRAMER_STATS_EN.
module rdmx_xmit_framer #(
   parameter int          DATA_WBITS = 512,
   parameter int          ADDR_WBITS = 64,
   parameter int          MAX_BEATS  = 256,
   parameter logic [31:0] MAGIC      = 32'h52444D58
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [ADDR_WBITS-1:0]     AXIS_ADDR_TDATA,
   input  logic                      AXIS_ADDR_TVALID,
   output logic                      AXIS_ADDR_TREADY,
   input  logic [15:0]               AXIS_PLEN_TDATA,
   input  logic                      AXIS_PLEN_TVALID,
   output logic                      AXIS_PLEN_TREADY,
   input  logic [DATA_WBITS-1:0]     AXIS_DATA_TDATA,
   input  logic                      AXIS_DATA_TLAST,
   input  logic                      AXIS_DATA_TVALID,
   output logic                      AXIS_DATA_TREADY,
   output logic [DATA_WBITS-1:0]     AXIS_TX_TDATA,
   output logic [DATA_WBITS/8-1:0]   AXIS_TX_TKEEP,
   output logic                      AXIS_TX_TLAST,
   output logic                      AXIS_TX_TVALID,
   input  logic                      AXIS_TX_TREADY
`ifdef RDMX_FRAMER_STATS_EN
   ,
   output logic [31:0]               STAT_FRAMES,
   output logic [47:0]               STAT_BYTES,
   output logic [31:0]               STAT_TRUNC
`endif
);

   localparam int KEEP_W   = DATA_WBITS / 8;
   localparam int KEEP_LSB = $clog2(KEEP_W);
   localparam int PTR_W    = $clog2(MAX_BEATS);
   localparam int CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

   typedef enum logic [1:0] {S_ADDR, S_DATA, S_HDR, S_DRAIN} state_t;

   state_t                  state_reg, state_next;
   logic [63:0]             addr_reg;
   logic [15:0]             plen_reg;
   logic [CNT_W-1:0]        beat_cnt_reg;
   logic                    trunc_reg;
   logic [CNT_W-1:0]        out_idx_reg;
   logic [DATA_WBITS-1:0]   rd_data_reg;
   logic [DATA_WBITS-1:0]   mem [MAX_BEATS];

   logic                    addr_hs, data_hs, plen_hs, tx_hs;
   logic                    buf_has_room, drain_last;
   logic [PTR_W-1:0]        rd_addr;
   logic [KEEP_LSB-1:0]     tail_bytes;
   logic [KEEP_W-1:0]       keep_last;
   logic [DATA_WBITS-1:0]   hdr_data;

   assign addr_hs      = AXIS_ADDR_TVALID & AXIS_ADDR_TREADY;
   assign data_hs      = AXIS_DATA_TVALID & AXIS_DATA_TREADY;
   assign plen_hs      = AXIS_PLEN_TVALID & AXIS_PLEN_TREADY;
   assign tx_hs        = AXIS_TX_TVALID & AXIS_TX_TREADY;
   assign buf_has_room = (beat_cnt_reg < MAX_CNT);
   assign drain_last   = (out_idx_reg == beat_cnt_reg - CNT_W'(1));
   assign tail_bytes   = plen_reg[KEEP_LSB-1:0];
   assign keep_last    = (tail_bytes == '0) ? '1
                         : ((KEEP_W'(1) << tail_bytes) - KEEP_W'(1));

   // Prefetch: advance the read address on the handshake so the next beat is ready without a bubble.
   assign rd_addr = (state_reg == S_DRAIN && tx_hs) ? out_idx_reg[PTR_W-1:0] + PTR_W'(1)
                                                     : out_idx_reg[PTR_W-1:0];

   always_comb begin
      hdr_data          = '0;
      hdr_data[31:0]    = MAGIC;
      hdr_data[47:32]   = plen_reg;
      hdr_data[56:48]   = 9'(beat_cnt_reg);
      hdr_data[63]      = trunc_reg;
      hdr_data[127:64]  = addr_reg;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= S_ADDR;
         addr_reg     <= '0;
         plen_reg     <= '0;
         beat_cnt_reg <= '0;
         trunc_reg    <= 1'b0;
         out_idx_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (addr_hs) begin
            addr_reg     <= 64'(AXIS_ADDR_TDATA);
            plen_reg     <= '0;
            beat_cnt_reg <= '0;
            trunc_reg    <= 1'b0;
            out_idx_reg  <= '0;
         end
         if (data_hs) begin
            if (buf_has_room)
               beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            else
               trunc_reg <= 1'b1;
         end
         if (plen_hs)
            plen_reg <= AXIS_PLEN_TDATA;
         if (state_reg == S_DRAIN && tx_hs)
            out_idx_reg <= out_idx_reg + CNT_W'(1);
      end
   end

   // Packet buffer kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (data_hs && buf_has_room)
         mem[beat_cnt_reg[PTR_W-1:0]] <= AXIS_DATA_TDATA;
      rd_data_reg <= mem[rd_addr];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_ADDR:  if (addr_hs) state_next = S_DATA;
         S_DATA:  if (data_hs && AXIS_DATA_TLAST) state_next = S_HDR;
         S_HDR:   if (tx_hs) state_next = (plen_reg == 16'd0) ? S_ADDR : S_DRAIN;
         S_DRAIN: if (tx_hs && drain_last) state_next = S_ADDR;
         default: state_next = S_ADDR;
      endcase
   end

   always_comb begin
      AXIS_ADDR_TREADY = 1'b0;
      AXIS_DATA_TREADY = 1'b0;
      AXIS_PLEN_TREADY = 1'b0;
      AXIS_TX_TVALID   = 1'b0;
      AXIS_TX_TDATA    = '0;
      AXIS_TX_TKEEP    = '0;
      AXIS_TX_TLAST    = 1'b0;
      if (resetn) begin
         case (state_reg)
            S_ADDR: AXIS_ADDR_TREADY = 1'b1;
            S_DATA: begin
               AXIS_DATA_TREADY = 1'b1;
               AXIS_PLEN_TREADY = 1'b1;
            end
            S_HDR: begin
               AXIS_TX_TVALID = 1'b1;
               AXIS_TX_TDATA  = hdr_data;
               AXIS_TX_TKEEP  = '1;
               AXIS_TX_TLAST  = (plen_reg == 16'd0);
            end
            S_DRAIN: begin
               AXIS_TX_TVALID = 1'b1;
               AXIS_TX_TDATA  = rd_data_reg;
               AXIS_TX_TKEEP  = drain_last ? keep_last : '1;
               AXIS_TX_TLAST  = drain_last;
            end
            default: ;
         endcase
      end
   end

`ifdef RDMX_FRAMER_STATS_EN
   logic [31:0] stat_frames_reg;
   logic [47:0] stat_bytes_reg;
   logic [31:0] stat_trunc_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_frames_reg <= '0;
         stat_bytes_reg  <= '0;
         stat_trunc_reg  <= '0;
      end else if (tx_hs && AXIS_TX_TLAST) begin
         stat_frames_reg <= stat_frames_reg + 32'd1;
         stat_bytes_reg  <= stat_bytes_reg + 48'(plen_reg);
         if (trunc_reg)
            stat_trunc_reg <= stat_trunc_reg + 32'd1;
      end
   end

   assign STAT_FRAMES = stat_frames_reg;
   assign STAT_BYTES  = stat_bytes_reg;
   assign STAT_TRUNC  = stat_trunc_reg;
`endif

endmodule
